// File: rtl/flash_timer_multi.sv
// -----------------------------------------------------------------------------
// flash_timer_multi
//   Bus-cycle wait generator for a StrataFlash controller. The controller
//   pulses start with a delay select; the block counts the selected number of
//   CLK_50MHZ cycles and returns a one-cycle done pulse. A running delay can be
//   cancelled with abort, in which case no done is produced.
//
//   Optional feature macro: FLASH_TIMER_PERIODIC_EN
//     Adds input 'periodic'. When it is captured high at accept, the timer
//     re-arms itself with the captured delay at every terminal count. This
//     produces a done pulse every D cycles until abort or reset. In this mode
//     done and busy can be high together.
//
// Parameters
//   CNT_W    counter / custom-delay width, bits
//   DLY_RD   sel=0 delay, cycles (read access)
//   DLY_WR   sel=1 delay, cycles (WE# pulse)
//   DLY_PRG  sel=2 delay, cycles (word program); must fit in CNT_W
//
// Ports
//   CLK_50MHZ  in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   start      in   request, sampled only while idle
//   sel        in   0=RD 1=WR 2=PRG 3=custom (dly_in)
//   dly_in     in   custom delay in cycles (sel=3)
//   periodic   in   re-arm at terminal count (FLASH_TIMER_PERIODIC_EN only)
//   abort      in   cancel a running delay; wins over start and terminal count
//   busy       out  high while a delay is running
//   done       out  one-cycle pulse at the end of a delay
//   remaining  out  cycles left including the current one; 0 when idle
// -----------------------------------------------------------------------------
module flash_timer_multi #(
  parameter int CNT_W   = 16,
  parameter int DLY_RD  = 4,
  parameter int DLY_WR  = 5,
  parameter int DLY_PRG = 10000
) (
  input  logic             CLK_50MHZ,
  input  logic             RST_N,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic [CNT_W-1:0] dly_in,
  input  logic             abort,
`ifdef FLASH_TIMER_PERIODIC_EN
  input  logic             periodic,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] dly_sel;
  logic [CNT_W-1:0] dly_eff;

`ifdef FLASH_TIMER_PERIODIC_EN
  // Delay and mode are held for reload at each terminal count.
  logic [CNT_W-1:0] dly_cap_q, dly_cap_d;
  logic             per_cap_q, per_cap_d;
`endif

  // Delay lookup; a zero delay is stretched to one cycle so the counter
  // always starts at >= 1 and can never wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    dly_sel = dly_in;
    case (sel)
      2'd0:    dly_sel = CNT_W'(DLY_RD);
      2'd1:    dly_sel = CNT_W'(DLY_WR);
      2'd2:    dly_sel = CNT_W'(DLY_PRG);
      default: dly_sel = dly_in;
    endcase
    dly_eff = (dly_sel == '0) ? CNT_W'(1) : dly_sel;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef FLASH_TIMER_PERIODIC_EN
    dly_cap_d = dly_cap_q;
    per_cap_d = per_cap_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cnt_d  = '0;
        // abort has priority: a simultaneous start is dropped.
        if (start && !abort) begin
          state_d = RUN;
          cnt_d   = dly_eff;
          busy_d  = 1'b1;
`ifdef FLASH_TIMER_PERIODIC_EN
          dly_cap_d = dly_eff;
          per_cap_d = periodic;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          // abort also beats the terminal count: no done is produced.
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          done_d = 1'b1;
`ifdef FLASH_TIMER_PERIODIC_EN
          if (per_cap_q) begin
            cnt_d  = dly_cap_q;
            busy_d = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FLASH_TIMER_PERIODIC_EN
      dly_cap_q <= '0;
      per_cap_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FLASH_TIMER_PERIODIC_EN
      dly_cap_q <= dly_cap_d;
      per_cap_q <= per_cap_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = cnt_q;

endmodule

// File: tb/tb_flash_timer_multi.sv
// -----------------------------------------------------------------------------
// tb_flash_timer_multi
//   Directed bench for flash_timer_multi with hand-computed expectations.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_flash_timer_multi;

  localparam int CNT_W = 16;

  logic             clk_50mhz;
  logic             rst_n;
  logic             start;
  logic [1:0]       sel;
  logic [CNT_W-1:0] dly_in;
  logic             abort;
`ifdef FLASH_TIMER_PERIODIC_EN
  logic             periodic;
`endif
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  int n_cmp;
  int n_bad;

  flash_timer_multi #(
    .CNT_W  (CNT_W),
    .DLY_RD (4),
    .DLY_WR (5),
    .DLY_PRG(10000)
  ) dut (
    .CLK_50MHZ(clk_50mhz),
    .RST_N    (rst_n),
    .start    (start),
    .sel      (sel),
    .dly_in   (dly_in),
    .abort    (abort),
`ifdef FLASH_TIMER_PERIODIC_EN
    .periodic (periodic),
`endif
    .busy     (busy),
    .done     (done),
    .remaining(remaining)
  );

  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  // Present a one-cycle start; returns at the falling edge after accept edge k.
  task automatic pulse_start(input logic [1:0] s, input logic [CNT_W-1:0] d);
    @(negedge clk_50mhz);
    start  = 1'b1;
    sel    = s;
    dly_in = d;
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    start = 1'b0;
  endtask

  task automatic test_reset;
    // Power-on reset values.
    n_cmp++;
    if ({busy, done, remaining} !== {1'b0, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_init: got busy=%b done=%b rem=%0d, want 0 0 0", busy, done, remaining);
    end
    // Reset in the middle of a word-program delay.
    pulse_start(2'd2, '0);
    repeat (20) @(negedge clk_50mhz);
    n_cmp++;
    if ({busy, remaining} !== {1'b1, 16'd9980}) begin
      n_bad++;
      $display("FAIL reset_precount: got busy=%b rem=%0d, want 1 9980", busy, remaining);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, remaining} !== {1'b0, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_async: got busy=%b done=%b rem=%0d, want 0 0 0", busy, done, remaining);
    end
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_50mhz);
      n_cmp++;
      if ({busy, done, remaining} !== {1'b0, 1'b0, 16'd0}) begin
        n_bad++;
        $display("FAIL reset_after%0d: got busy=%b done=%b rem=%0d, want 0 0 0", i, busy, done, remaining);
      end
    end
  endtask

  task automatic test_read;
    logic             exp_busy;
    logic             exp_done;
    logic [CNT_W-1:0] exp_rem;
    pulse_start(2'd0, 16'd77);
    sel = 2'd2;  // must be ignored after accept
    for (int j = 0; j <= 5; j++) begin
      if (j < 4)       begin exp_busy = 1'b1; exp_done = 1'b0; exp_rem = CNT_W'(4 - j); end
      else if (j == 4) begin exp_busy = 1'b0; exp_done = 1'b1; exp_rem = '0; end
      else             begin exp_busy = 1'b0; exp_done = 1'b0; exp_rem = '0; end
      n_cmp++;
      if ({busy, done, remaining} !== {exp_busy, exp_done, exp_rem}) begin
        n_bad++;
        $display("FAIL read_k+%0d: got busy=%b done=%b rem=%0d, want %b %b %0d",
                 j, busy, done, remaining, exp_busy, exp_done, exp_rem);
      end
      if (j < 5) @(negedge clk_50mhz);
    end
  endtask

  task automatic test_custom_zero;
    pulse_start(2'd3, 16'd0);
    n_cmp++;
    if ({busy, done, remaining} !== {1'b1, 1'b0, 16'd1}) begin
      n_bad++;
      $display("FAIL zero_k: got busy=%b done=%b rem=%0d, want 1 0 1", busy, done, remaining);
    end
    @(negedge clk_50mhz);
    n_cmp++;
    if ({busy, done, remaining} !== {1'b0, 1'b1, 16'd0}) begin
      n_bad++;
      $display("FAIL zero_k+1: got busy=%b done=%b rem=%0d, want 0 1 0", busy, done, remaining);
    end
    @(negedge clk_50mhz);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_k+2: got done=%b, want 0", done);
    end
  endtask

  task automatic test_custom_max;
    int cyc;
    int bad_busy;
    pulse_start(2'd3, 16'hFFFF);
    n_cmp++;
    if ({busy, remaining} !== {1'b1, 16'hFFFF}) begin
      n_bad++;
      $display("FAIL max_k: got busy=%b rem=%0d, want 1 65535", busy, remaining);
    end
    dly_in   = 16'd3;  // must be ignored after accept
    cyc      = 0;
    bad_busy = 0;
    while (cyc < 70000) begin
      @(negedge clk_50mhz);
      cyc++;
      if (done) break;
      if (busy !== 1'b1) bad_busy++;
      if (cyc == 100) begin
        n_cmp++;
        if (remaining !== 16'd65435) begin
          n_bad++;
          $display("FAIL max_rem100: got rem=%0d, want 65435", remaining);
        end
      end
    end
    n_cmp++;
    if (cyc !== 65535) begin
      n_bad++;
      $display("FAIL max_done_cycle: got done after %0d edges, want 65535", cyc);
    end
    n_cmp++;
    if (bad_busy !== 0) begin
      n_bad++;
      $display("FAIL max_busy: got %0d cycles with busy low, want 0", bad_busy);
    end
  endtask

  task automatic test_back_to_back;
    logic             exp_busy;
    logic             exp_done;
    logic [CNT_W-1:0] exp_rem;
    int               p;
    @(negedge clk_50mhz);
    start  = 1'b1;
    sel    = 2'd1;
    dly_in = 16'd2;
    @(posedge clk_50mhz);
    for (int j = 0; j < 18; j++) begin
      @(negedge clk_50mhz);
      if (j == 8) dly_in = 16'd9;
      p = j % 6;
      if (p < 5) begin exp_busy = 1'b1; exp_done = 1'b0; exp_rem = CNT_W'(5 - p); end
      else       begin exp_busy = 1'b0; exp_done = 1'b1; exp_rem = '0; end
      n_cmp++;
      if ({busy, done, remaining} !== {exp_busy, exp_done, exp_rem}) begin
        n_bad++;
        $display("FAIL b2b_k+%0d: got busy=%b done=%b rem=%0d, want %b %b %0d",
                 j, busy, done, remaining, exp_busy, exp_done, exp_rem);
      end
    end
    start = 1'b0;  // dropped in the final done cycle: no re-accept
    @(negedge clk_50mhz);
    n_cmp++;
    if ({busy, done, remaining} !== {1'b0, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL b2b_end: got busy=%b done=%b rem=%0d, want 0 0 0", busy, done, remaining);
    end
  endtask

  task automatic test_abort;
    int seen_done;
    pulse_start(2'd2, '0);
    seen_done = 0;
    repeat (9999) begin
      @(negedge clk_50mhz);
      if (done) seen_done++;
    end
    n_cmp++;
    if ({busy, remaining} !== {1'b1, 16'd1}) begin
      n_bad++;
      $display("FAIL abort_rem1: got busy=%b rem=%0d, want 1 1", busy, remaining);
    end
    abort = 1'b1;
    @(negedge clk_50mhz);
    abort = 1'b0;
    n_cmp++;
    if ({busy, done, remaining} !== {1'b0, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL abort_term: got busy=%b done=%b rem=%0d, want 0 0 0", busy, done, remaining);
    end
    repeat (3) begin
      @(negedge clk_50mhz);
      if (done) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0) begin
      n_bad++;
      $display("FAIL abort_nodone: got %0d done pulses, want 0", seen_done);
    end
    // abort together with start while idle: start must be dropped.
    start = 1'b1;
    abort = 1'b1;
    sel   = 2'd0;
    @(negedge clk_50mhz);
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if ({busy, done, remaining} !== {1'b0, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL abort_start_idle: got busy=%b done=%b rem=%0d, want 0 0 0", busy, done, remaining);
    end
    repeat (5) @(negedge clk_50mhz);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_start_later: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

`ifdef FLASH_TIMER_PERIODIC_EN
  task automatic test_periodic;
    logic             exp_done;
    logic [CNT_W-1:0] exp_rem;
    int               seen_done;
    periodic = 1'b1;
    pulse_start(2'd0, '0);
    periodic = 1'b0;  // captured at accept; later value ignored
    for (int j = 0; j <= 9; j++) begin
      exp_done = (j == 4 || j == 8);
      exp_rem  = CNT_W'(4 - (j % 4));
      n_cmp++;
      if ({busy, done, remaining} !== {1'b1, exp_done, exp_rem}) begin
        n_bad++;
        $display("FAIL per_k+%0d: got busy=%b done=%b rem=%0d, want 1 %b %0d",
                 j, busy, done, remaining, exp_done, exp_rem);
      end
      if (j < 9) @(negedge clk_50mhz);
    end
    abort = 1'b1;
    @(negedge clk_50mhz);
    abort = 1'b0;
    seen_done = 0;
    n_cmp++;
    if ({busy, done, remaining} !== {1'b0, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL per_abort: got busy=%b done=%b rem=%0d, want 0 0 0", busy, done, remaining);
    end
    repeat (8) begin
      @(negedge clk_50mhz);
      if (done || busy) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0) begin
      n_bad++;
      $display("FAIL per_after_abort: got %0d active cycles, want 0", seen_done);
    end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    sel    = 2'd0;
    dly_in = '0;
    abort  = 1'b0;
`ifdef FLASH_TIMER_PERIODIC_EN
    periodic = 1'b0;
`endif
    repeat (2) @(negedge clk_50mhz);
    rst_n = 1'b1;
    @(negedge clk_50mhz);

    test_reset();
    test_read();
    test_custom_zero();
    test_custom_max();
    test_back_to_back();
    test_abort();
`ifdef FLASH_TIMER_PERIODIC_EN
    test_periodic();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
